// File: rtl/mux_pkg.sv
// Shared constants and helpers for the round-robin / select multiplexer.
package mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // Ceiling log2; used to size select and channel-ID fields.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester found searching upward
// from ptr+1, wrapping modulo N_CH.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int unsigned N_CH = 4,
    parameter int unsigned SW   = clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [SW-1:0]   ptr,
    output logic [N_CH-1:0] grant,
    output logic            valid
);

    int unsigned idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int unsigned k = 1; k <= N_CH; k++) begin
            idx = (32'(ptr) + k) % N_CH;
            if (!valid && req[SW'(idx)]) begin
                grant[SW'(idx)] = 1'b1;
                valid           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux.sv
// N-channel to one multiplexer with external-select or round-robin
// arbitration and a single registered output stage.
module rr_mux
    import mux_pkg::*;
#(
    parameter int unsigned N_CH = 4,
    parameter int unsigned W    = 8,
    parameter int unsigned SW   = clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [SW-1:0]     select,
    input  logic [N_CH*W-1:0] in_data,
    input  logic [N_CH-1:0]   in_valid,
    output logic [N_CH-1:0]   in_ready,
    output logic [W-1:0]      out_data,
    output logic [SW-1:0]     out_ch,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [SW-1:0]   ptr_q, ptr_d;
    logic [W-1:0]    out_data_q, out_data_d;
    logic [SW-1:0]   out_ch_q, out_ch_d;
    logic            out_valid_q, out_valid_d;

    logic [N_CH-1:0] rr_grant;
    logic            rr_any;
    logic [N_CH-1:0] sel_grant;
    logic [N_CH-1:0] grant_vec;
    logic            grant_any;
    logic [SW-1:0]   grant_ch;
    logic [W-1:0]    grant_data;
    logic            load_c;
    logic            xfer_c;

    rr_arbiter #(
        .N_CH (N_CH),
        .SW   (SW)
    ) u_arb (
        .req   (in_valid),
        .ptr   (ptr_q),
        .grant (rr_grant),
        .valid (rr_any)
    );

    // External select; out-of-range select matches no channel and grants nothing.
    always_comb begin
        sel_grant = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (select == SW'(i) && in_valid[i]) sel_grant[i] = 1'b1;
        end
    end

    always_comb begin
        grant_vec  = (mode == MODE_RR) ? rr_grant : sel_grant;
        grant_any  = (mode == MODE_RR) ? rr_any : (|sel_grant);
        grant_ch   = '0;
        grant_data = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (grant_vec[i]) begin
                grant_ch   = SW'(i);
                grant_data = in_data[i*W +: W];
            end
        end
    end

    assign load_c   = !out_valid_q || out_ready;
    assign xfer_c   = grant_any && load_c && !rst;
    assign in_ready = (rst || !load_c) ? '0 : grant_vec;

    // Output stage and pointer next-state; an idle load drains out_valid only.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (load_c) begin
            out_valid_d = grant_any;
            if (grant_any) begin
                out_data_d = grant_data;
                out_ch_d   = grant_ch;
            end
        end
        if (xfer_c && mode == MODE_RR) ptr_d = grant_ch;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= SW'(N_CH - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux.sv
// Self-checking bench for rr_mux: directed scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_rr_mux;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          mode;
    logic [SW-1:0] select;
    logic [N*W-1:0] in_data;
    logic [N-1:0]  in_valid;
    logic [N-1:0]  in_ready;
    logic [W-1:0]  out_data;
    logic [SW-1:0] out_ch;
    logic          out_valid;
    logic          out_ready;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    bit         m_valid = 1'b0;
    logic [W-1:0] m_data = '0;
    int         m_ch  = 0;
    int         m_ptr = N - 1;
    int         cur_g;
    bit         cur_load;
    logic [N-1:0] exp_ready;

    rr_mux #(.N_CH(N), .W(W), .SW(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .select    (select),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Winner from the arbitration rules; -1 when nobody is granted.
    function automatic int model_grant();
        if (mode == 1'b0) begin
            if (int'(select) < N && in_valid[select]) return int'(select);
            return -1;
        end
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic predict();
        #1;
        cur_g    = model_grant();
        cur_load = !m_valid || out_ready;
        if (rst || !cur_load || cur_g < 0) exp_ready = '0;
        else exp_ready = N'(1 << cur_g);
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = N - 1;
        end else if (cur_load) begin
            if (cur_g >= 0) begin
                m_valid = 1'b1;
                m_data  = in_data[cur_g*W +: W];
                m_ch    = cur_g;
                if (mode) m_ptr = cur_g;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            rst = 1'b1; mode = 1'(c); select = SW'(c); in_data = $urandom;
            in_valid = '1; out_ready = 1'b1;
            predict();
            n_cmp++;
            if (in_ready !== 4'b0000) begin
                n_err++; $display("FAIL reset_in_ready: got %b want 0000", in_ready);
            end
            advance();
            n_cmp++;
            if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
                n_err++;
                $display("FAIL reset_outputs: got v=%b d=%h ch=%0d want v=0 d=00 ch=0",
                         out_valid, out_data, out_ch);
            end
        end
    endtask

    task automatic test_sel_basic();
        rst = 1'b0; mode = 1'b0; select = 2'd2; in_data = 32'h44332211;
        in_valid = 4'hF; out_ready = 1'b1;
        predict();
        n_cmp++;
        if (in_ready !== 4'b0100) begin
            n_err++; $display("FAIL sel_in_ready: got %b want 0100", in_ready);
        end
        advance();
        n_cmp++;
        if (out_data !== 8'h33 || out_ch !== 2'd2 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL sel_output: got d=%h ch=%0d v=%b want d=33 ch=2 v=1",
                     out_data, out_ch, out_valid);
        end
    endtask

    task automatic test_rr_all();
        logic [W-1:0] want_d;
        rst = 1'b1; predict(); advance();
        rst = 1'b0; mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_data = $urandom;
            want_d  = in_data[(k%N)*W +: W];
            predict();
            n_cmp++;
            if (in_ready !== 4'(1 << (k % N)) || !$onehot(in_ready)) begin
                n_err++; $display("FAIL rr_all_ready[%0d]: got %b want %b",
                                  k, in_ready, 4'(1 << (k % N)));
            end
            advance();
            n_cmp++;
            if (out_ch !== 2'(k % N) || out_valid !== 1'b1 || out_data !== want_d) begin
                n_err++;
                $display("FAIL rr_all_out[%0d]: got ch=%0d v=%b d=%h want ch=%0d v=1 d=%h",
                         k, out_ch, out_valid, out_data, k % N, want_d);
            end
        end
    endtask

    task automatic test_rr_sparse();
        int seq [4] = '{1, 3, 1, 3};
        rst = 1'b1; predict(); advance();
        rst = 1'b0; mode = 1'b1; in_valid = 4'b1010; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = $urandom;
            predict();
            n_cmp++;
            if (in_ready !== 4'(1 << seq[k])) begin
                n_err++; $display("FAIL rr_sparse_ready[%0d]: got %b want %b",
                                  k, in_ready, 4'(1 << seq[k]));
            end
            advance();
            n_cmp++;
            if (out_ch !== 2'(seq[k]) || out_valid !== 1'b1) begin
                n_err++; $display("FAIL rr_sparse_out[%0d]: got ch=%0d v=%b want ch=%0d v=1",
                                  k, out_ch, out_valid, seq[k]);
            end
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] held;
        rst = 1'b1; predict(); advance();
        rst = 1'b0; mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        in_data = $urandom;
        held = in_data[0 +: W];
        predict(); advance();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_data = $urandom;
            predict();
            n_cmp++;
            if (in_ready !== 4'b0000) begin
                n_err++; $display("FAIL stall_ready[%0d]: got %b want 0000", k, in_ready);
            end
            advance();
            n_cmp++;
            if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== held) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got v=%b ch=%0d d=%h want v=1 ch=0 d=%h",
                         k, out_valid, out_ch, out_data, held);
            end
        end
        out_ready = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            in_data = $urandom;
            predict();
            n_cmp++;
            if (in_ready !== 4'(1 << k)) begin
                n_err++; $display("FAIL release_ready[%0d]: got %b want %b",
                                  k, in_ready, 4'(1 << k));
            end
            advance();
            n_cmp++;
            if (out_valid !== 1'b1 || out_ch !== 2'(k)) begin
                n_err++; $display("FAIL release_out[%0d]: got v=%b ch=%0d want v=1 ch=%0d",
                                  k, out_valid, out_ch, k);
            end
        end
    endtask

    task automatic test_no_grant();
        logic [W-1:0] held_d;
        int           held_ch;
        held_d = m_data; held_ch = m_ch;
        mode = 1'b0; select = 2'd1; in_valid = 4'b1101; out_ready = 1'b1;
        in_data = $urandom;
        predict();
        n_cmp++;
        if (in_ready !== 4'b0000) begin
            n_err++; $display("FAIL nogrant_ready: got %b want 0000", in_ready);
        end
        advance();
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== held_d || out_ch !== 2'(held_ch)) begin
            n_err++;
            $display("FAIL nogrant_out: got v=%b d=%h ch=%0d want v=0 d=%h ch=%0d",
                     out_valid, out_data, out_ch, held_d, held_ch);
        end
    endtask

    task automatic test_reset_stall();
        rst = 1'b0; mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1; in_data = $urandom;
        predict(); advance();
        out_ready = 1'b0; rst = 1'b1;
        predict();
        n_cmp++;
        if (in_ready !== 4'b0000) begin
            n_err++; $display("FAIL rststall_ready: got %b want 0000", in_ready);
        end
        advance();
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
            n_err++;
            $display("FAIL rststall_out: got v=%b d=%h ch=%0d want v=0 d=00 ch=0",
                     out_valid, out_data, out_ch);
        end
        rst = 1'b0; out_ready = 1'b1;
        predict();
        n_cmp++;
        if (in_ready !== 4'b0001) begin
            n_err++; $display("FAIL rststall_first_ready: got %b want 0001", in_ready);
        end
        advance();
        n_cmp++;
        if (out_valid !== 1'b1 || out_ch !== 2'd0) begin
            n_err++; $display("FAIL rststall_first_out: got v=%b ch=%0d want v=1 ch=0",
                              out_valid, out_ch);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            rst       = ($urandom_range(0, 39) == 0);
            mode      = 1'($urandom);
            select    = SW'($urandom);
            in_valid  = N'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 9) < 7);
            predict();
            n_cmp++;
            if (in_ready !== exp_ready) begin
                n_err++; $display("FAIL rand_ready[%0d]: got %b want %b", c, in_ready, exp_ready);
            end
            advance();
            n_cmp++;
            if (out_valid !== m_valid) begin
                n_err++; $display("FAIL rand_valid[%0d]: got %b want %b", c, out_valid, m_valid);
            end
            n_cmp++;
            if (out_data !== m_data || out_ch !== 2'(m_ch)) begin
                n_err++; $display("FAIL rand_out[%0d]: got d=%h ch=%0d want d=%h ch=%0d",
                                  c, out_data, out_ch, m_data, m_ch);
            end
        end
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; select = '0; in_data = '0; in_valid = '0; out_ready = 1'b0;
        test_reset();
        test_sel_basic();
        test_rr_all();
        test_rr_sparse();
        test_stall();
        test_no_grant();
        test_reset_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rr_mux.md
RR_MUX -- requirements
Module: rr_mux

Interface
REQ-001 Parameter N_CH, default 4, number of input channels; legal range 2..16.
REQ-002 Parameter W, default 8, data width per channel in bits; legal range 1..64.
REQ-003 Parameter SW, default clog2(N_CH), width of the select and channel-ID fields.
REQ-004 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 Port rst  input  1  reset, synchronous and active-high.
REQ-006 Port mode  input  1  arbitration mode: 0 = external select, 1 = round-robin.
REQ-007 Port select  input  SW  channel to forward when mode = 0.
REQ-008 Port in_data  input  N_CH*W  channel i occupies bits [i*W +: W].
REQ-009 Port in_valid  input  N_CH  channel i presents data.
REQ-010 Port in_ready  output  N_CH  channel i data is accepted this cycle.
REQ-011 Port out_data  output  W  registered forwarded data.
REQ-012 Port out_ch  output  SW  source channel of out_data.
REQ-013 Port out_valid  output  1  out_data holds an untaken word.
REQ-014 Port out_ready  input  1  downstream accepts out_data.

Function
REQ-015 The output stage SHALL be a single register with load = !out_valid | out_ready.
REQ-016 Mode 0: grant SHALL equal select when in_valid[select] = 1; otherwise no grant is issued.
REQ-017 Mode 0: select >= N_CH SHALL produce no grant.
REQ-018 Mode 1: grant SHALL be the first valid channel searched upward from ptr+1, wrapping modulo N_CH.
REQ-019 in_ready[i] SHALL be 1 only when i is granted and load = 1; at most one bit SHALL be set; in_ready is combinational.
REQ-020 On a transfer (in_valid[g] & in_ready[g]), the next edge SHALL load out_data = in_data[g], out_ch = g, out_valid = 1; latency is one cycle.
REQ-021 When load = 1 and no grant is issued, out_valid SHALL go to 0; out_data and out_ch SHALL hold.
REQ-022 When load = 0, out_data, out_ch and out_valid SHALL hold; stall depth is one word.
REQ-023 Simultaneous out_ready and a new transfer SHALL sustain one word per cycle with no bubble.
REQ-024 ptr SHALL update to g only on a Mode 1 transfer; it SHALL hold in Mode 0 and on idle cycles.
REQ-025 Changing mode mid-stream SHALL take effect on the same cycle's grant; the word already in the register is unaffected.
REQ-026 Wrap-around: with ptr = N_CH-1, the search SHALL start at channel 0.

Reset
REQ-027 While rst = 1 at a clock edge: out_valid = 0, out_data = 0, out_ch = 0, ptr = N_CH-1.
REQ-028 While rst = 1, in_ready SHALL be all zeros.
REQ-029 Reset during a stall SHALL discard the held word; no input is accepted on the reset cycle.

Structure
REQ-030 Shared package mux_pkg SHALL hold the constants MODE_SEL = 0 and MODE_RR = 1 and the clog2 helper function.
REQ-031 Round-robin grant logic SHALL be a sub-module rr_arbiter (inputs: req, ptr; output: one-hot grant plus valid), purely combinational.
REQ-032 The ptr register and the output register SHALL live in rr_mux.

Verification
REQ-033 Mode 0, N_CH=4, W=8, in_data = {8'h44,8'h33,8'h22,8'h11}, all valid, select = 2, out_ready = 1 -> in_ready = 4'b0100; out_data = 8'h33, out_ch = 2 one cycle later.
REQ-034 Mode 1, all four valid, out_ready = 1 for 5 cycles after reset -> out_ch sequence 0,1,2,3,0; in_ready one-hot each cycle.
REQ-035 Mode 1, in_valid = 4'b1010, ptr = 3 -> grants 1,3,1,3; channels 0 and 2 never granted.
REQ-036 out_valid = 1, out_ready = 0 for 3 cycles with all inputs valid -> in_ready = 0, out_data and out_ch stable; on release, the next word follows with no bubble.
REQ-037 Mode 0, select = 1, in_valid[1] = 0 with out_ready = 1 -> out_valid drops to 0 next cycle; out_data unchanged.
REQ-038 rst asserted while a word is stalled -> next cycle out_valid = 0, out_data = 0, out_ch = 0; first Mode 1 grant afterward is channel 0.
